// File: rtl/pwm_spi_pkg.sv
// Constants and FSM encoding shared by the SPI PWM host and the PWM driver.
// The command byte layout is {write, 5'b0, addr}.
package pwm_spi_pkg;

    localparam int         NUM_CHANNELS  = 4;
    localparam int         CMD_WRITE_BIT = 7;
    localparam int         CMD_ADDR_LSB  = 0;
    localparam int         CMD_ADDR_MSB  = 1;
    localparam logic [7:0] FILL_BYTE     = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } spi_state_t;

    function automatic logic [7:0] make_cmd(input logic write, input logic [1:0] addr);
        logic [7:0] cmd;
        cmd                             = FILL_BYTE;
        cmd[CMD_WRITE_BIT]              = write;
        cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]  = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counter marking the last clk cycle of each sclk phase (HALF_PERIOD cycles long).
// 'restart' reloads the counter so the next phase starts a full HALF_PERIOD later.
module spi_phase_timer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic expire
);

    localparam int             CW   = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0]  LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || restart || count == '0) begin
            count <= LAST;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/spi_pwm_host.sv
// SPI initiator for the 4-channel PWM driver: one request becomes one SPI frame
// (cmd byte, data/fill byte, optional echo byte); the response is a one-cycle pulse.
module spi_pwm_host
    import pwm_spi_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter bit WRITE_ECHO  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    spi_state_t  state_q, next_state;
    logic        expire;
    logic        accept;
    logic [23:0] frame;
    logic [22:0] tx_q;
    logic [7:0]  rx_q;
    logic [7:0]  data_q;
    logic        is_write;
    logic [4:0]  bit_cnt;

    // Timer is held in reload while idle so SETUP is always a full phase.
    spi_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (state_q == ST_IDLE),
        .expire  (expire)
    );

    assign accept = (state_q == ST_IDLE) && req_ready && req_valid;
    assign frame  = {make_cmd(req_write, req_addr),
                     req_write ? req_data : FILL_BYTE,
                     FILL_BYTE};

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:  if (accept) next_state = ST_SETUP;
            ST_SETUP: if (expire) next_state = ST_HIGH;
            ST_HIGH:  if (expire) next_state = ST_LOW;
            ST_LOW:   if (expire) next_state = (bit_cnt == 5'd0) ? ST_GAP : ST_HIGH;
            ST_GAP:   if (expire) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            is_write  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state_q   <= next_state;
            cs        <= (next_state == ST_IDLE) || (next_state == ST_GAP);
            sclk      <= (next_state == ST_HIGH);
            req_ready <= (next_state == ST_IDLE);
            rsp_valid <= (state_q == ST_GAP) && expire;

            if (accept) begin
                is_write <= req_write;
                data_q   <= req_data;
                tx_q     <= frame[22:0];
                mosi     <= frame[23];
                bit_cnt  <= (req_write && WRITE_ECHO) ? 5'd23 : 5'd15;
            end

            // Only the final byte of the frame carries response data, LSB first.
            if (state_q == ST_HIGH && expire) begin
                if (bit_cnt < 5'd8) begin
                    rx_q <= {miso, rx_q[7:1]};
                end
                tx_q <= {tx_q[21:0], 1'b0};
                mosi <= (bit_cnt == 5'd0) ? 1'b0 : tx_q[22];
            end

            if (state_q == ST_LOW && expire && bit_cnt != 5'd0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            if (state_q == ST_GAP && expire) begin
                rsp_data <= (is_write && !WRITE_ECHO) ? FILL_BYTE : rx_q;
                rsp_err  <= WRITE_ECHO && is_write && (rx_q != data_q);
            end
        end
    end

endmodule

// File: tb/tb_spi_pwm_host.sv
// Bench for spi_pwm_host: a behavioural PWM-driver SPI target, a level model that predicts
// each response at issue time, and a monitor that checks responses and frames as they appear.
module tb_spi_pwm_host;

    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso = 1'b0;

    spi_pwm_host #(.HALF_PERIOD(H), .WRITE_ECHO(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int cs_falls = 0;
    bit fault = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] data; logic err; int due; } rsp_t;
    typedef struct { logic [23:0] bits; int n; } frm_t;
    rsp_t exp_q[$];
    frm_t frm_q[$];

    logic [7:0] model_level [4];
    logic [7:0] drv_level   [4];

    // Behavioural driver: commits a write after 16 bits, answers reads in byte 2 and
    // echoes the stored level in byte 3, always LSB first.
    int          s_cnt = 0;
    logic [23:0] s_shift = '0;
    logic [7:0]  s_cmd = '0;

    always @(negedge cs) begin
        s_cnt   = 0;
        s_shift = '0;
        s_cmd   = '0;
        cs_falls++;
    end

    always @(posedge sclk) begin
        if (cs === 1'b0) begin
            s_shift = {s_shift[22:0], mosi};
            s_cnt++;
            if (s_cnt == 8) s_cmd = s_shift[7:0];
            if (s_cnt == 16 && s_cmd[7]) drv_level[s_cmd[1:0]] = s_shift[7:0];
            miso = 1'b0;
            if (!s_cmd[7] && s_cnt >= 9 && s_cnt <= 16)
                miso = drv_level[s_cmd[1:0]][s_cnt-9];
            if (s_cmd[7] && s_cnt >= 17 && s_cnt <= 24 && !fault)
                miso = drv_level[s_cmd[1:0]][s_cnt-17];
        end
    end

    always @(posedge cs) begin
        frm_t f;
        if (reset_n === 1'b1) begin
            if (frm_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                f = frm_q.pop_front();
                check("frame_len", s_cnt, f.n);
                check("frame_bits", {8'h00, s_shift}, {8'h00, f.bits});
            end
        end
    end

    always @(negedge clk) begin
        rsp_t r;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check("rsp_data", {24'h0, rsp_data}, {24'h0, r.data});
                check("rsp_err", {31'h0, rsp_err}, {31'h0, r.err});
                check("rsp_time", cyc, r.due);
            end
        end
        if (reset_n === 1'b1 && cs === 1'b1 && (sclk !== 1'b0 || mosi !== 1'b0)) viol++;
    end

    // Drive one request; if track is set, predict the frame and response from the model.
    task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input bit track, input int hold);
        int         waited;
        int         n;
        logic [7:0] cmd;
        rsp_t       r;
        frm_t       f;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        while (req_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            n   = w ? 24 : 16;
            cmd = {w, 5'b00000, a};
            if (w) begin
                r.data = fault ? 8'h00 : d;
                r.err  = fault && (d != 8'h00);
                model_level[a] = d;
                f.bits = {cmd, d, 8'h00};
            end else begin
                r.data = model_level[a];
                r.err  = 1'b0;
                f.bits = {8'h00, cmd, 8'h00};
            end
            f.n   = n;
            r.due = cyc + 1 + (2 * n + 2) * H;
            exp_q.push_back(r);
            frm_q.push_back(f);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_write = 1'($urandom_range(1, 0));
            req_addr  = 2'($urandom_range(3, 0));
            req_data  = 8'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        int         falls0;

        for (int i = 0; i < 4; i++) begin
            model_level[i] = 8'h00;
            drv_level[i]   = 8'h00;
        end

        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_cs", cs, 1);
        check("reset_sclk", sclk, 0);
        check("reset_mosi", mosi, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Directed sequence; consecutive issues also exercise back-to-back accepts.
        issue(1'b0, 2'd3, 8'h00, 1'b1, 0);
        issue(1'b1, 2'd2, 8'h80, 1'b1, 0);
        issue(1'b0, 2'd2, 8'h00, 1'b1, 0);
        issue(1'b1, 2'd0, 8'hFF, 1'b1, 0);
        issue(1'b0, 2'd0, 8'h00, 1'b1, 0);
        drain();

        // Echo fault: driver still stores the level but echoes zeros.
        fault = 1'b1;
        issue(1'b1, 2'd1, 8'h5A, 1'b1, 0);
        drain();
        fault = 1'b0;
        issue(1'b0, 2'd1, 8'h00, 1'b1, 0);
        drain();

        // Request held and scrambled while busy must produce exactly one frame.
        falls0 = cs_falls;
        issue(1'b0, 2'd2, 8'h00, 1'b1, 60);
        drain();
        check("single_accept", cs_falls - falls0, 1);

        // Abort mid command byte; the driver never sees 16 bits so nothing is committed.
        issue(1'b1, 2'd1, 8'hC3, 1'b0, 0);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'd1, 8'h00, 1'b1, 0);
        drain();

        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(1, 0));
            a = 2'($urandom_range(3, 0));
            d = 8'($urandom);
            issue(w, a, d, 1'b1, 0);
        end
        drain();

        check("frames_left", frm_q.size(), 0);
        check("protocol_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
